dac_2comp_out: RTL and testbench

Output-side counterpart of the ADC input conversion. It takes two signed two's-complement DAC channel words from the processing core. Each channel is saturated to the DAC width, clamped to programmable limits and slew-rate limited. The result is encoded into the DAC's native inverted-offset code, sign bit kept and remaining bits inverted, so that two's-complement 0 drives midscale. The block sits between the locking/servo datapath and the DAC output pins.

---
 rtl/dac_2comp_out.sv | 195 +++++++++++++++++++
 tb/tb_dac_2comp_out.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_2comp_out.sv
// ---------------------------------------------------------------------------
// dac_2comp_out
//
// Output-side conversion for the two DAC channels. Each signed
// two's-complement sample from the processing core goes through three steps:
// it is saturated to the DAC width and clamped to the programmable limits,
// then slew-rate limited, and finally encoded into the DAC's inverted-offset
// code. In that code two's-complement 0 maps to midscale.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   dac_a_i      channel A sample, signed, in_bits wide
//   dac_b_i      channel B sample, signed, in_bits wide
//   valid_i      qualifies dac_a_i/dac_b_i, one sample per high cycle
//   en_i         output enable; low ramps both channels to 0
//   hi_lim       signed upper clamp shared by both channels
//   lo_lim       signed lower clamp shared by both channels (wins over hi_lim)
//   slew_step    unsigned max change per clock, 0 disables slew limiting
//   sat_clr_i    clears the sticky saturation flags
//   dac_a_o      channel A DAC code
//   dac_b_o      channel B DAC code
//   valid_o      valid_i delayed three clocks
//   sat_a_o      sticky: a channel A sample was clipped
//   sat_b_o      sticky: a channel B sample was clipped
//   ramp_busy_o  a channel is still slewing toward its target
// ---------------------------------------------------------------------------
module dac_2comp_out #(
    parameter int in_bits = 16,
    parameter int bits    = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [in_bits-1:0]   dac_a_i,
    input  logic [in_bits-1:0]   dac_b_i,
    input  logic                 valid_i,
    input  logic                 en_i,
    input  logic [bits-1:0]      hi_lim,
    input  logic [bits-1:0]      lo_lim,
    input  logic [bits-1:0]      slew_step,
    input  logic                 sat_clr_i,
    output logic [bits-1:0]      dac_a_o,
    output logic [bits-1:0]      dac_b_o,
    output logic                 valid_o,
    output logic                 sat_a_o,
    output logic                 sat_b_o,
    output logic                 ramp_busy_o
);

    localparam logic signed [in_bits-1:0] SAT_HI = in_bits'((2 ** (bits - 1)) - 1);
    localparam logic signed [in_bits-1:0] SAT_LO = in_bits'(-(2 ** (bits - 1)));
    localparam logic [bits-1:0]           MIDSCALE = {1'b0, {(bits - 1){1'b1}}};

    logic signed [bits-1:0] tgt_a;
    logic signed [bits-1:0] tgt_b;
    logic signed [bits-1:0] cur_a;
    logic signed [bits-1:0] cur_b;
    logic [bits:0]          clamp_a;
    logic [bits:0]          clamp_b;
    logic signed [bits-1:0] next_a;
    logic signed [bits-1:0] next_b;
    logic [2:0]             valid_pipe;

    // Saturate to the DAC range, then apply hi_lim, then lo_lim. Applying
    // lo_lim last is what makes it win when the limits are crossed.
    // Returns {clipped, value}.
    function automatic logic [bits:0] clamp_word(
        input logic [in_bits-1:0] x,
        input logic [bits-1:0]    hi,
        input logic [bits-1:0]    lo
    );
        logic signed [in_bits-1:0] s;
        logic signed [in_bits-1:0] hi_w;
        logic signed [in_bits-1:0] lo_w;
        logic                      clip;
        s    = $signed(x);
        hi_w = in_bits'($signed(hi));
        lo_w = in_bits'($signed(lo));
        clip = 1'b0;
        if (s > SAT_HI) begin
            s    = SAT_HI;
            clip = 1'b1;
        end else if (s < SAT_LO) begin
            s    = SAT_LO;
            clip = 1'b1;
        end
        if (s > hi_w) begin
            s    = hi_w;
            clip = 1'b1;
        end
        if (s < lo_w) begin
            s    = lo_w;
            clip = 1'b1;
        end
        return {clip, s[bits-1:0]};
    endfunction

    // One slew step toward the target. The difference needs bits+1 bits
    // because target and current can sit at opposite ends of the range.
    // A partial step always lands between cur and tgt, so it cannot overflow.
    function automatic logic signed [bits-1:0] slew_next(
        input logic signed [bits-1:0] cur,
        input logic signed [bits-1:0] tgt,
        input logic [bits-1:0]        step
    );
        logic signed [bits:0] cur_w;
        logic signed [bits:0] diff;
        logic signed [bits:0] mag;
        logic signed [bits:0] step_w;
        logic signed [bits:0] res;
        cur_w  = {cur[bits-1], cur};
        diff   = {tgt[bits-1], tgt} - cur_w;
        mag    = (diff < 0) ? -diff : diff;
        step_w = {1'b0, step};
        if (step == '0 || mag <= step_w) begin
            res = {tgt[bits-1], tgt};
        end else if (diff < 0) begin
            res = cur_w - step_w;
        end else begin
            res = cur_w + step_w;
        end
        return res[bits-1:0];
    endfunction

    assign clamp_a = clamp_word(dac_a_i, hi_lim, lo_lim);
    assign clamp_b = clamp_word(dac_b_i, hi_lim, lo_lim);
    assign next_a  = slew_next(cur_a, tgt_a, slew_step);
    assign next_b  = slew_next(cur_b, tgt_b, slew_step);

    // Stage 1: the target registers. Disabling the output forces both
    // targets to 0, so the slew stage ramps down gracefully.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_a <= '0;
            tgt_b <= '0;
        end else if (!en_i) begin
            tgt_a <= '0;
            tgt_b <= '0;
        end else if (valid_i) begin
            tgt_a <= clamp_a[bits-1:0];
            tgt_b <= clamp_b[bits-1:0];
        end
    end

    // Sticky clip flags. A new clip takes priority over a clear in the
    // same cycle so that the event is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_a_o <= 1'b0;
            sat_b_o <= 1'b0;
        end else begin
            if (en_i && valid_i && clamp_a[bits]) begin
                sat_a_o <= 1'b1;
            end else if (sat_clr_i) begin
                sat_a_o <= 1'b0;
            end
            if (en_i && valid_i && clamp_b[bits]) begin
                sat_b_o <= 1'b1;
            end else if (sat_clr_i) begin
                sat_b_o <= 1'b0;
            end
        end
    end

    // Stage 2: the slew-limited current values, plus a busy flag reflecting
    // whether either channel had not yet reached its target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_a       <= '0;
            cur_b       <= '0;
            ramp_busy_o <= 1'b0;
        end else begin
            cur_a       <= next_a;
            cur_b       <= next_b;
            ramp_busy_o <= (cur_a != tgt_a) || (cur_b != tgt_b);
        end
    end

    // Stage 3: inverted-offset encoding. The sign bit is kept and the rest
    // is inverted, so 0 becomes midscale. This is also the reset code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_a_o    <= MIDSCALE;
            dac_b_o    <= MIDSCALE;
            valid_pipe <= '0;
        end else begin
            dac_a_o    <= {cur_a[bits-1], ~cur_a[bits-2:0]};
            dac_b_o    <= {cur_b[bits-1], ~cur_b[bits-2:0]};
            valid_pipe <= {valid_pipe[1:0], valid_i};
        end
    end

    assign valid_o = valid_pipe[2];

endmodule

// File: tb/tb_dac_2comp_out.sv
// ---------------------------------------------------------------------------
// tb_dac_2comp_out
//
// Self-checking bench for dac_2comp_out (in_bits=16, bits=14).
// Each driven sample pushes the expected output codes and the cycle they
// must appear on. A monitor pops the queue on every valid_o and compares.
// The slew, enable and reset sequences are also checked cycle by cycle
// against values computed here.
// ---------------------------------------------------------------------------
module tb_dac_2comp_out;

    logic        clk;
    logic        rst;
    logic [15:0] dac_a_i;
    logic [15:0] dac_b_i;
    logic        valid_i;
    logic        en_i;
    logic [13:0] hi_lim;
    logic [13:0] lo_lim;
    logic [13:0] slew_step;
    logic        sat_clr_i;
    logic [13:0] dac_a_o;
    logic [13:0] dac_b_o;
    logic        valid_o;
    logic        sat_a_o;
    logic        sat_b_o;
    logic        ramp_busy_o;

    typedef struct {
        logic [13:0] code_a;
        logic [13:0] code_b;
        int          due;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        cycle;
    int        compared;
    int        mismatched;

    dac_2comp_out #(.in_bits(16), .bits(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .dac_a_i     (dac_a_i),
        .dac_b_i     (dac_b_i),
        .valid_i     (valid_i),
        .en_i        (en_i),
        .hi_lim      (hi_lim),
        .lo_lim      (lo_lim),
        .slew_step   (slew_step),
        .sat_clr_i   (sat_clr_i),
        .dac_a_o     (dac_a_o),
        .dac_b_o     (dac_b_o),
        .valid_o     (valid_o),
        .sat_a_o     (sat_a_o),
        .sat_b_o     (sat_b_o),
        .ramp_busy_o (ramp_busy_o)
    );

    // 10 ns clock with the rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so that expected latencies can be checked.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Encode a signed value the way the DAC expects it.
    function automatic logic [13:0] enc(input int v);
        logic [13:0] t;
        t = v[13:0];
        return {t[13], ~t[12:0]};
    endfunction

    // Reference clamp: saturate to the 14-bit range, then hi, then lo.
    function automatic int clampModel(input int x, input int hi, input int lo);
        int s;
        s = x;
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    // Count one comparison and report it when the value is wrong.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic pushExpected(input logic [13:0] ea, input logic [13:0] eb);
        sb_entry_t e;
        e.code_a = ea;
        e.code_b = eb;
        e.due    = cycle + 3;
        sb.push_back(e);
    endtask

    // Drive one sample for a single cycle and record the expected codes.
    task automatic applyStimulus(input int a, input int b, input logic [13:0] ea, input logic [13:0] eb);
        @(negedge clk);
        dac_a_i = a[15:0];
        dac_b_i = b[15:0];
        valid_i = 1'b1;
        pushExpected(ea, eb);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) checkOutput("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic pulseClear();
        @(negedge clk);
        sat_clr_i = 1'b1;
        @(negedge clk);
        sat_clr_i = 1'b0;
    endtask

    // Scoreboard monitor: every valid_o must match the oldest pending sample.
    always @(negedge clk) begin
        if (rst && valid_o) begin
            if (sb.size() == 0) begin
                checkOutput("valid_o_spurious", 32'(valid_o), 0);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                checkOutput("sb_dac_a", 32'(dac_a_o), 32'(e.code_a));
                checkOutput("sb_dac_b", 32'(dac_b_o), 32'(e.code_b));
                checkOutput("sb_latency", cycle, e.due);
            end
        end
    end

    // Hard time limit so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cycle      = 0;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        dac_a_i    = '0;
        dac_b_i    = '0;
        valid_i    = 1'b0;
        en_i       = 1'b1;
        hi_lim     = 14'd8191;
        lo_lim     = 14'h2000;
        slew_step  = '0;
        sat_clr_i  = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_dac_a", 32'(dac_a_o), 32'h1FFF);
        checkOutput("rst_dac_b", 32'(dac_b_o), 32'h1FFF);
        checkOutput("rst_flags", 32'({valid_o, sat_a_o, sat_b_o, ramp_busy_o}), 0);
        rst = 1'b1;

        // Passthrough with full limits and no slew.
        applyStimulus(256, -1, enc(clampModel(256, 8191, -8192)), enc(clampModel(-1, 8191, -8192)));
        waitDrain();
        checkOutput("pass_a_code", 32'(dac_a_o), 32'h1EFF);
        checkOutput("pass_b_code", 32'(dac_b_o), 32'h2000);
        applyStimulus(-4000, 3000, enc(-4000), enc(3000));
        waitDrain();

        // Saturation and the sticky flag.
        applyStimulus(32767, 0, 14'h0000, enc(0));
        waitDrain();
        checkOutput("sat_a_set", 32'(sat_a_o), 1);
        checkOutput("sat_b_clear", 32'(sat_b_o), 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("sat_a_sticky", 32'(sat_a_o), 1);
        pulseClear();
        checkOutput("sat_a_cleared", 32'(sat_a_o), 0);
        @(negedge clk);
        dac_a_i   = 16'h7FFF;
        dac_b_i   = 16'h0000;
        valid_i   = 1'b1;
        sat_clr_i = 1'b1;
        pushExpected(enc(8191), enc(0));
        @(negedge clk);
        valid_i   = 1'b0;
        sat_clr_i = 1'b0;
        checkOutput("sat_set_wins", 32'(sat_a_o), 1);
        waitDrain();

        // Programmable clamps, including crossed limits.
        hi_lim = 14'd1000;
        lo_lim = 14'(-500);
        pulseClear();
        applyStimulus(2000, -900, enc(clampModel(2000, 1000, -500)), enc(clampModel(-900, 1000, -500)));
        waitDrain();
        checkOutput("clamp_a_code", 32'(dac_a_o), 32'(enc(1000)));
        checkOutput("clamp_sat_a", 32'(sat_a_o), 1);
        checkOutput("clamp_sat_b", 32'(sat_b_o), 1);
        hi_lim = 14'd5;
        lo_lim = 14'd10;
        applyStimulus(0, 7, enc(clampModel(0, 5, 10)), enc(clampModel(7, 5, 10)));
        waitDrain();
        checkOutput("crossed_lo_wins", 32'(dac_a_o), 32'(enc(10)));

        // Slew ramp 0 -> 1000 in steps of 100.
        hi_lim = 14'd8191;
        lo_lim = 14'h2000;
        applyStimulus(0, 0, enc(0), enc(0));
        waitDrain();
        slew_step = 14'd100;
        applyStimulus(1000, 0, enc(100), enc(0));
        @(negedge clk);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            checkOutput($sformatf("ramp_up_%0d", j), 32'(dac_a_o), 32'(enc(100 * j)));
            checkOutput($sformatf("ramp_busy_%0d", j), 32'(ramp_busy_o), (j < 10) ? 1 : 0);
        end
        waitDrain();

        // Retarget mid-ramp: ramp down from 500 with no jump.
        slew_step = '0;
        applyStimulus(0, 0, enc(0), enc(0));
        waitDrain();
        slew_step = 14'd100;
        applyStimulus(1000, 0, enc(100), enc(0));
        for (int j = 0; j < 3; j++) @(negedge clk);
        applyStimulus(0, 0, enc(400), enc(0));
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("retarget_%0d", i), 32'(dac_a_o), 32'(enc(500 - 100 * i)));
            checkOutput($sformatf("retarget_busy_%0d", i), 32'(ramp_busy_o), (i < 5) ? 1 : 0);
        end
        waitDrain();

        // Enable low ramps to zero and ignores valid_i.
        slew_step = '0;
        applyStimulus(1000, 0, enc(1000), enc(0));
        waitDrain();
        pulseClear();
        slew_step = 14'd100;
        @(negedge clk);
        en_i = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            @(negedge clk);
            if (m == 3) begin
                dac_a_i = 16'h7FFF;
                dac_b_i = 16'h7FFF;
                valid_i = 1'b1;
                pushExpected(enc(600), enc(0));
            end else begin
                valid_i = 1'b0;
            end
            if (m >= 2) checkOutput($sformatf("en_ramp_%0d", m), 32'(dac_a_o), 32'(enc(1200 - 100 * m)));
        end
        checkOutput("en_final_code", 32'(dac_a_o), 32'h1FFF);
        checkOutput("en_no_sat", 32'({sat_a_o, sat_b_o}), 0);
        checkOutput("en_busy_done", 32'(ramp_busy_o), 0);
        en_i = 1'b1;
        waitDrain();

        // Reset in the middle of a ramp returns straight to midscale.
        applyStimulus(1000, -32768, enc(100), enc(-100));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_dac_a", 32'(dac_a_o), 32'(enc(200)));
        checkOutput("pre_rst_sat_b", 32'(sat_b_o), 1);
        checkOutput("pre_rst_busy", 32'(ramp_busy_o), 1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_dac_a", 32'(dac_a_o), 32'h1FFF);
        checkOutput("mid_rst_dac_b", 32'(dac_b_o), 32'h1FFF);
        checkOutput("mid_rst_flags", 32'({valid_o, sat_a_o, sat_b_o, ramp_busy_o}), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        checkOutput("post_rst_dac_a", 32'(dac_a_o), 32'h1FFF);
        checkOutput("post_rst_queue", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
